// File: rtl/payment_pkg.sv
// rtl/payment_pkg.sv - shared types and constants for the payment sequencer
package payment_pkg;

   localparam int MONEY_W  = 5;
   localparam int CREDIT_W = 6;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'b000,
      ST_COLLECT  = 3'b001,
      ST_VALIDATE = 3'b010,
      ST_CHANGE   = 3'b011,
      ST_REFUND   = 3'b100
   } state_t;

   localparam logic [MONEY_W-1:0] DENOM_10 = 5'd10;
   localparam logic [MONEY_W-1:0] DENOM_20 = 5'd20;
   localparam logic [MONEY_W-1:0] DENOM_30 = 5'd30;

   // True when the inserted item is one of the accepted denominations.
   function automatic logic is_denom(input logic [MONEY_W-1:0] value);
      return (value == DENOM_10) || (value == DENOM_20) || (value == DENOM_30);
   endfunction

endpackage

// File: rtl/payment_timer.sv
// rtl/payment_timer.sv - inactivity counter with clear, increment and expire
module payment_timer #(
   parameter int TIMEOUT_CYCLES = 1000
) (
   input  logic clock,
   input  logic reset,
   input  logic clear,
   input  logic inc,
   output logic expire
);

   localparam int W = $clog2(TIMEOUT_CYCLES);
   localparam logic [W-1:0] LAST = W'(TIMEOUT_CYCLES - 1);

   logic [W-1:0] count;

   // Clear has priority over increment; the count never runs past LAST
   // because the sequencer leaves COLLECT on the cycle expire is seen.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (inc) begin
         count <= count + 1'b1;
      end
   end

   assign expire = (count == LAST);

endmodule

// File: rtl/payment_sequencer.sv
// rtl/payment_sequencer.sv - checkout payment FSM with credit and change
module payment_sequencer
   import payment_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 1000
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       start,
   input  logic [4:0] price,
   input  logic       money_valid,
   input  logic [4:0] money,
   input  logic       cancel,
   output logic       busy,
   output logic       accepted,
   output logic       rejected,
   output logic       change_valid,
   output logic [4:0] change,
   output logic       paid,
   output logic       refunded,
   output logic [4:0] credit,
   output logic [2:0] state
);

   state_t state_q, state_d;

   logic [MONEY_W-1:0]  price_q, price_d;
   logic [MONEY_W-1:0]  coin_q, coin_d;
   logic [MONEY_W-1:0]  pend_q, pend_d;
   logic [MONEY_W-1:0]  credit_d;
   logic [MONEY_W-1:0]  change_d;
   logic [CREDIT_W-1:0] sum;
   logic                accepted_d, rejected_d, change_valid_d, paid_d, refunded_d;
   logic                tmr_clear, tmr_inc, tmr_expire;

   // Credit plus coin fits six bits: credit is below price (<=30) and coin <=30.
   assign sum = {1'b0, credit} + {1'b0, coin_q};

   payment_timer #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_timer (
      .clock (clock),
      .reset (reset),
      .clear (tmr_clear),
      .inc   (tmr_inc),
      .expire(tmr_expire)
   );

   // Next-state and next-output decode; every output is registered below.
   always_comb begin
      state_d        = state_q;
      price_d        = price_q;
      coin_d         = coin_q;
      pend_d         = pend_q;
      credit_d       = credit;
      change_d       = change;
      accepted_d     = 1'b0;
      rejected_d     = 1'b0;
      change_valid_d = 1'b0;
      paid_d         = 1'b0;
      refunded_d     = 1'b0;
      tmr_clear      = 1'b0;
      tmr_inc        = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (start && (price != '0)) begin
               price_d   = price;
               credit_d  = '0;
               tmr_clear = 1'b1;
               state_d   = ST_COLLECT;
            end
         end

         ST_COLLECT: begin
            if (cancel) begin
               rejected_d = money_valid;
               state_d    = ST_REFUND;
            end else if (money_valid) begin
               coin_d    = money;
               tmr_clear = 1'b1;
               state_d   = ST_VALIDATE;
            end else if (tmr_expire) begin
               state_d = ST_REFUND;
            end else begin
               tmr_inc = 1'b1;
            end
         end

         ST_VALIDATE: begin
            state_d = ST_COLLECT;
            if (is_denom(coin_q)) begin
               accepted_d = 1'b1;
               if (sum >= {1'b0, price_q}) begin
                  // Change is at most 29, so the low five bits are exact.
                  pend_d  = sum[MONEY_W-1:0] - price_q;
                  state_d = ST_CHANGE;
               end else begin
                  credit_d = sum[MONEY_W-1:0];
               end
            end else begin
               rejected_d = 1'b1;
            end
         end

         ST_CHANGE: begin
            change_d       = pend_q;
            change_valid_d = 1'b1;
            paid_d         = 1'b1;
            credit_d       = '0;
            state_d        = ST_IDLE;
         end

         ST_REFUND: begin
            change_d       = credit;
            change_valid_d = 1'b1;
            refunded_d     = 1'b1;
            credit_d       = '0;
            state_d        = ST_IDLE;
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and output registers; busy follows the state one cycle later.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         price_q      <= '0;
         coin_q       <= '0;
         pend_q       <= '0;
         busy         <= 1'b0;
         accepted     <= 1'b0;
         rejected     <= 1'b0;
         change_valid <= 1'b0;
         change       <= '0;
         paid         <= 1'b0;
         refunded     <= 1'b0;
         credit       <= '0;
      end else begin
         state_q      <= state_d;
         price_q      <= price_d;
         coin_q       <= coin_d;
         pend_q       <= pend_d;
         busy         <= (state_q != ST_IDLE);
         accepted     <= accepted_d;
         rejected     <= rejected_d;
         change_valid <= change_valid_d;
         change       <= change_d;
         paid         <= paid_d;
         refunded     <= refunded_d;
         credit       <= credit_d;
      end
   end

   assign state = state_q;

endmodule

// File: tb/tb_payment_sequencer.sv
// tb/tb_payment_sequencer.sv - directed and randomized checks of payment_sequencer
module tb_payment_sequencer;

   logic       clock;
   logic       reset;
   logic       start;
   logic [4:0] price;
   logic       money_valid;
   logic [4:0] money;
   logic       cancel;
   logic       busy;
   logic       accepted;
   logic       rejected;
   logic       change_valid;
   logic [4:0] change;
   logic       paid;
   logic       refunded;
   logic [4:0] credit;
   logic [2:0] state;

   int vectors;
   int miscompares;

   int m_price;
   int m_credit;
   bit m_done;

   payment_sequencer #(
      .TIMEOUT_CYCLES(8)
   ) dut (
      .clock       (clock),
      .reset       (reset),
      .start       (start),
      .price       (price),
      .money_valid (money_valid),
      .money       (money),
      .cancel      (cancel),
      .busy        (busy),
      .accepted    (accepted),
      .rejected    (rejected),
      .change_valid(change_valid),
      .change      (change),
      .paid        (paid),
      .refunded    (refunded),
      .credit      (credit),
      .state       (state)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   function automatic bit legal_coin(input int v);
      return (v == 10) || (v == 20) || (v == 30);
   endfunction

   task automatic do_start(input int p);
      @(negedge clock);
      start = 1'b1;
      price = 5'(p);
      @(negedge clock);
      start = 1'b0;
      check("start_state", 32'(state), 32'd1);
      check("start_credit", 32'(credit), 32'd0);
      m_price  = p;
      m_credit = 0;
      m_done   = 1'b0;
   endtask

   task automatic insert(input int v);
      bit legal;
      @(negedge clock);
      money_valid = 1'b1;
      money       = 5'(v);
      @(negedge clock);
      money_valid = 1'b0;
      check("validate_state", 32'(state), 32'd2);
      check("busy_txn", 32'(busy), 32'd1);
      @(negedge clock);
      legal = legal_coin(v);
      check("accepted", 32'(accepted), 32'(legal));
      check("rejected", 32'(rejected), 32'(!legal));
      if (legal) m_credit = m_credit + v;
      if (legal && m_credit >= m_price) begin
         @(negedge clock);
         check("paid", 32'(paid), 32'd1);
         check("paid_cv", 32'(change_valid), 32'd1);
         check("paid_change", 32'(change), 32'(m_credit - m_price));
         check("paid_no_refund", 32'(refunded), 32'd0);
         check("paid_state", 32'(state), 32'd0);
         check("paid_credit", 32'(credit), 32'd0);
         @(negedge clock);
         check("paid_busy_low", 32'(busy), 32'd0);
         check("paid_one_cycle", 32'(paid), 32'd0);
         m_credit = 0;
         m_done   = 1'b1;
      end else begin
         check("credit", 32'(credit), 32'(m_credit));
         check("collect_state", 32'(state), 32'd1);
         m_done = 1'b0;
      end
   endtask

   task automatic do_cancel(input bit with_money, input int v);
      @(negedge clock);
      cancel      = 1'b1;
      money_valid = with_money;
      money       = 5'(v);
      @(negedge clock);
      cancel      = 1'b0;
      money_valid = 1'b0;
      check("cancel_rejected", 32'(rejected), 32'(with_money));
      check("cancel_no_accept", 32'(accepted), 32'd0);
      check("cancel_state", 32'(state), 32'd4);
      @(negedge clock);
      check("refunded", 32'(refunded), 32'd1);
      check("refund_cv", 32'(change_valid), 32'd1);
      check("refund_change", 32'(change), 32'(m_credit));
      check("refund_no_paid", 32'(paid), 32'd0);
      check("refund_state", 32'(state), 32'd0);
      check("refund_credit", 32'(credit), 32'd0);
      m_credit = 0;
      m_done   = 1'b1;
   endtask

   initial begin
      int n;
      bit seen;
      int r;
      int steps;
      int coin;
      int denoms[3];

      denoms[0] = 10;
      denoms[1] = 20;
      denoms[2] = 30;
      vectors     = 0;
      miscompares = 0;
      m_price     = 0;
      m_credit    = 0;
      m_done      = 1'b0;

      reset       = 1'b1;
      start       = 1'b0;
      price       = '0;
      money_valid = 1'b0;
      money       = '0;
      cancel      = 1'b0;

      @(negedge clock);
      @(negedge clock);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_accepted", 32'(accepted), 32'd0);
      check("rst_rejected", 32'(rejected), 32'd0);
      check("rst_change_valid", 32'(change_valid), 32'd0);
      check("rst_change", 32'(change), 32'd0);
      check("rst_paid", 32'(paid), 32'd0);
      check("rst_refunded", 32'(refunded), 32'd0);
      check("rst_credit", 32'(credit), 32'd0);
      check("rst_state", 32'(state), 32'd0);
      reset = 1'b0;

      // Zero price start is ignored.
      @(negedge clock);
      start = 1'b1;
      price = 5'd0;
      @(negedge clock);
      start = 1'b0;
      check("zero_price_state", 32'(state), 32'd0);

      // Money while idle produces nothing.
      money_valid = 1'b1;
      money       = 5'd10;
      @(negedge clock);
      money_valid = 1'b0;
      @(negedge clock);
      check("idle_money_state", 32'(state), 32'd0);
      check("idle_money_acc", 32'(accepted), 32'd0);
      check("idle_money_rej", 32'(rejected), 32'd0);

      // Exact pay.
      do_start(20);
      insert(20);

      // Overpay with change; a start while collecting is ignored.
      do_start(25);
      @(negedge clock);
      start = 1'b1;
      price = 5'd5;
      @(negedge clock);
      start = 1'b0;
      check("start_busy_ignored", 32'(state), 32'd1);
      insert(10);
      insert(10);
      insert(30);

      // Invalid denomination then a good one.
      do_start(10);
      insert(7);
      insert(10);

      // Cancel together with money.
      do_start(30);
      insert(20);
      do_cancel(1'b1, 10);

      // Timeout after eight quiet COLLECT cycles.
      do_start(15);
      insert(10);
      n    = 0;
      seen = 1'b0;
      for (int i = 0; i < 40; i++) begin
         if (state == 3'd1) n++;
         if (refunded) begin
            seen = 1'b1;
            break;
         end
         @(negedge clock);
      end
      check("timeout_seen", 32'(seen), 32'd1);
      check("timeout_cycles", 32'(n), 32'd8);
      check("timeout_change", 32'(change), 32'd10);
      check("timeout_cv", 32'(change_valid), 32'd1);
      m_credit = 0;

      // Asynchronous reset in the middle of COLLECT.
      do_start(30);
      insert(10);
      #2;
      reset = 1'b1;
      #1;
      check("async_rst_state", 32'(state), 32'd0);
      check("async_rst_credit", 32'(credit), 32'd0);
      check("async_rst_refund", 32'(refunded), 32'd0);
      @(negedge clock);
      reset    = 1'b0;
      m_credit = 0;

      // Randomized transactions.
      repeat (25) begin
         do_start($urandom_range(1, 31));
         steps = 0;
         while (!m_done && steps < 8) begin
            r = $urandom_range(0, 9);
            if (r <= 6) coin = denoms[$urandom_range(0, 2)];
            else coin = $urandom_range(0, 31);
            if (r == 0) do_cancel(1'($urandom_range(0, 1)), coin);
            else insert(coin);
            steps++;
         end
         if (!m_done) do_cancel(1'b0, 0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
